// File: rtl/mc_maindec.sv
// -----------------------------------------------------------------------------
// mc_maindec
// Multicycle main controller for the MIPS core. Walks each instruction through
// fetch / decode / execute / memory / writeback and decodes the current state
// into the datapath enables for that cycle. Memory accesses wait on mem_ready,
// BNE decode is optional, and an unknown opcode parks the controller in a trap
// state with a sticky illegal flag until reset.
//
// State table (state | meaning):
//   IDLE    (0)  | out of reset, nothing driven
//   FETCH   (1)  | read instruction at PC, PC+4 when memory responds
//   DECODE  (2)  | register read, branch target precompute, opcode dispatch
//   MEMADR  (3)  | effective address for LW/SW
//   MEMRD   (4)  | load data read, waits for mem_ready
//   MEMWB   (5)  | load data written to rt
//   MEMWR   (6)  | store write strobe, held until mem_ready
//   RTYPEEX (7)  | ALU operation selected by funct
//   RTYPEWB (8)  | ALU result written to rd
//   BEQEX   (9)  | compare, PC takes branch target on zero
//   ADDIEX  (10) | register + sign-extended immediate
//   ADDIWB  (11) | ADDI result written to rt
//   JEX     (12) | PC takes jump target
//   BNEEX   (13) | compare, PC takes branch target on non-zero
//   TRAP    (14) | illegal opcode seen, frozen until reset
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   op         - opcode field of the instruction register
//   mem_ready  - memory finished its access this cycle
//   memwrite, iord, irwrite, pcwrite, branch, branch_ne, alusrca, alusrcb,
//   pcsrc, regdst, memtoreg, regwrite, aluop
//              - datapath controls decoded from the current state
//   illegal    - sticky illegal-opcode flag
//   state_o    - current state encoding, for debug
// -----------------------------------------------------------------------------
module mc_maindec #(
    parameter int OPW    = 6,
    parameter bit EN_BNE = 1'b1,
    parameter int STW    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] op,
    input  logic           mem_ready,
    output logic           memwrite,
    output logic           iord,
    output logic           irwrite,
    output logic           pcwrite,
    output logic           branch,
    output logic           branch_ne,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic [1:0]     aluop,
    output logic           illegal,
    output logic [STW-1:0] state_o
);

    typedef enum logic [STW-1:0] {
        S_IDLE    = STW'(0),
        S_FETCH   = STW'(1),
        S_DECODE  = STW'(2),
        S_MEMADR  = STW'(3),
        S_MEMRD   = STW'(4),
        S_MEMWB   = STW'(5),
        S_MEMWR   = STW'(6),
        S_RTYPEEX = STW'(7),
        S_RTYPEWB = STW'(8),
        S_BEQEX   = STW'(9),
        S_ADDIEX  = STW'(10),
        S_ADDIWB  = STW'(11),
        S_JEX     = STW'(12),
        S_BNEEX   = STW'(13),
        S_TRAP    = STW'(14)
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic. op only matters in DECODE and MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:      state_d = S_RTYPEEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BEQEX;
                    OP_BNE:        state_d = EN_BNE ? S_BNEEX : S_TRAP;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_J:          state_d = S_JEX;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_BNEEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            // Encoding 15 cannot be reached normally; recover via IDLE.
            default:   state_d = S_IDLE;
        endcase
    end

    // Flag rises on the same edge that enters TRAP and only reset clears it.
    always_comb begin
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    // Output decode. Only FETCH looks at an input: the IR load and PC+4
    // write must coincide with the cycle memory actually returns the word.
    always_comb begin
        memwrite  = 1'b0;
        iord      = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        aluop     = 2'b00;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_BNEEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                branch_ne = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign illegal = illegal_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
module tb_mc_maindec;

    typedef struct packed {
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] aluop;
        logic       illegal;
    } out_t;

    typedef struct {
        int         which;
        logic [3:0] st;
        out_t       o;
        string      tag;
    } exp_t;

    localparam logic [5:0] X    = 6'b111111;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] J    = 6'b000010;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;

    logic       memwrite1, iord1, irwrite1, pcwrite1, branch1, branch_ne1, alusrca1;
    logic [1:0] alusrcb1, pcsrc1, aluop1;
    logic       regdst1, memtoreg1, regwrite1, illegal1;
    logic [3:0] state1;

    logic       memwrite0, iord0, irwrite0, pcwrite0, branch0, branch_ne0, alusrca0;
    logic [1:0] alusrcb0, pcsrc0, aluop0;
    logic       regdst0, memtoreg0, regwrite0, illegal0;
    logic [3:0] state0;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    event chk_ev;

    always #5 clk = ~clk;

    mc_maindec #(.OPW(6), .EN_BNE(1'b1), .STW(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .memwrite(memwrite1), .iord(iord1), .irwrite(irwrite1), .pcwrite(pcwrite1),
        .branch(branch1), .branch_ne(branch_ne1), .alusrca(alusrca1), .alusrcb(alusrcb1),
        .pcsrc(pcsrc1), .regdst(regdst1), .memtoreg(memtoreg1), .regwrite(regwrite1),
        .aluop(aluop1), .illegal(illegal1), .state_o(state1)
    );

    mc_maindec #(.OPW(6), .EN_BNE(1'b0), .STW(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .memwrite(memwrite0), .iord(iord0), .irwrite(irwrite0), .pcwrite(pcwrite0),
        .branch(branch0), .branch_ne(branch_ne0), .alusrca(alusrca0), .alusrcb(alusrcb0),
        .pcsrc(pcsrc0), .regdst(regdst0), .memtoreg(memtoreg0), .regwrite(regwrite0),
        .aluop(aluop0), .illegal(illegal0), .state_o(state0)
    );

    // Hand-written per-state output table.
    function automatic out_t exp_out(input logic [3:0] st, input logic mr);
        out_t o;
        o = '0;
        case (st)
            4'd1:  begin o.alusrcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
            4'd2:  begin o.alusrcb = 2'b11; end
            4'd3:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            4'd4:  begin o.iord = 1'b1; end
            4'd5:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
            4'd6:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
            4'd7:  begin o.alusrca = 1'b1; o.aluop = 2'b10; end
            4'd8:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            4'd9:  begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.branch = 1'b1; end
            4'd10: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            4'd11: begin o.regwrite = 1'b1; end
            4'd12: begin o.pcsrc = 2'b10; o.pcwrite = 1'b1; end
            4'd13: begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.branch_ne = 1'b1; end
            4'd14: begin o.illegal = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic push(input int which, input logic [3:0] st, input logic mr, input string tag);
        exp_t e;
        e.which = which;
        e.st    = st;
        e.o     = exp_out(st, mr);
        e.tag   = tag;
        sb.push_back(e);
    endtask

    // One clock of stimulus: inputs for this cycle plus the state each DUT
    // should be in during it.
    task automatic step(input logic [5:0] o, input logic mr,
                        input logic [3:0] s1, input logic [3:0] s0, input string tag);
        @(posedge clk);
        #1;
        op        = o;
        mem_ready = mr;
        push(1, s1, mr, tag);
        push(0, s0, mr, tag);
    endtask

    // Pulse reset between edges and check the outputs drop without a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        push(1, 4'd0, mem_ready, tag);
        push(0, 4'd0, mem_ready, tag);
        -> chk_ev;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        push(1, 4'd0, mem_ready, {tag, "_rel"});
        push(0, 4'd0, mem_ready, {tag, "_rel"});
        -> chk_ev;
    endtask

    // Monitor: pops everything queued and compares against the live outputs.
    initial begin
        exp_t e;
        out_t a;
        logic [3:0] ast;
        forever begin
            @(negedge clk or chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.which == 1) begin
                    a   = {memwrite1, iord1, irwrite1, pcwrite1, branch1, branch_ne1, alusrca1,
                           alusrcb1, pcsrc1, regdst1, memtoreg1, regwrite1, aluop1, illegal1};
                    ast = state1;
                end else begin
                    a   = {memwrite0, iord0, irwrite0, pcwrite0, branch0, branch_ne0, alusrca0,
                           alusrcb0, pcsrc0, regdst0, memtoreg0, regwrite0, aluop0, illegal0};
                    ast = state0;
                end
                n_vec++;
                if (ast !== e.st || a !== e.o) begin
                    n_err++;
                    $display("FAIL %s dut%0d @%0t: state=%0d outs=%05h, required state=%0d outs=%05h",
                             e.tag, e.which, $time, ast, a, e.st, e.o);
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        op        = RT;
        mem_ready = 1'b0;
        #3;
        push(1, 4'd0, mem_ready, "reset");
        push(0, 4'd0, mem_ready, "reset");
        -> chk_ev;
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // R-type: 0 -> 1,2,7,8 -> 1
        step(X,    1, 1, 1, "rt_fetch");
        step(RT,   1, 2, 2, "rt_dec");
        step(X,    0, 7, 7, "rt_ex");
        step(BNE,  1, 8, 8, "rt_wb");

        // FETCH wait, then LW with two MEMRD wait cycles
        step(X,    0, 1, 1, "fetch_wait");
        step(X,    1, 1, 1, "lw_fetch");
        step(LW,   1, 2, 2, "lw_dec");
        step(LW,   1, 3, 3, "lw_adr");
        step(X,    0, 4, 4, "lw_rd0");
        step(X,    0, 4, 4, "lw_rd1");
        step(X,    1, 4, 4, "lw_rd2");
        step(X,    1, 5, 5, "lw_wb");

        // SW with two MEMWR wait cycles: memwrite for three cycles
        step(X,    1, 1, 1, "sw_fetch");
        step(SW,   1, 2, 2, "sw_dec");
        step(SW,   1, 3, 3, "sw_adr");
        step(X,    0, 6, 6, "sw_wr0");
        step(X,    0, 6, 6, "sw_wr1");
        step(X,    1, 6, 6, "sw_wr2");

        // op re-sampled in MEMADR: decoded as LW, becomes SW at MEMADR
        step(X,    1, 1, 1, "adr_fetch");
        step(LW,   1, 2, 2, "adr_dec");
        step(SW,   1, 3, 3, "adr_resample");
        step(X,    1, 6, 6, "adr_wr");

        // BEQ, ADDI, J
        step(X,    1, 1, 1, "beq_fetch");
        step(BEQ,  1, 2, 2, "beq_dec");
        step(X,    1, 9, 9, "beq_ex");
        step(X,    1, 1, 1, "addi_fetch");
        step(ADDI, 1, 2, 2, "addi_dec");
        step(X,    1, 10, 10, "addi_ex");
        step(X,    1, 11, 11, "addi_wb");
        step(X,    1, 1, 1, "j_fetch");
        step(J,    1, 2, 2, "j_dec");
        step(X,    1, 12, 12, "j_ex");

        // Reset in the middle of a store
        step(X,    1, 1, 1, "swr_fetch");
        step(SW,   1, 2, 2, "swr_dec");
        step(SW,   1, 3, 3, "swr_adr");
        step(X,    0, 6, 6, "swr_wr");
        async_reset("rst_memwr");

        // BNE: dut1 branches, dut0 traps and stays trapped
        step(X,    1, 1, 1, "bne_fetch");
        step(BNE,  1, 2, 2, "bne_dec");
        step(X,    1, 13, 14, "bne_ex");
        for (int i = 0; i < 4; i++) begin
            step(X, 1, 1, 14, "trap_hold_f");
            step(J, 1, 2, 14, "trap_hold_d");
            step(X, 1, 12, 14, "trap_hold_j");
        end

        // Illegal opcode on dut1 as well
        step(X,    1, 1, 14, "ill_fetch");
        step(X,    1, 2, 14, "ill_dec");
        for (int i = 0; i < 4; i++) begin
            step(RT, 1, 14, 14, "ill_hold");
        end

        // Reset clears the trap and the sticky flag
        async_reset("rst_trap");
        step(X,    1, 1, 1, "post_rst_fetch");
        step(RT,   1, 2, 2, "post_rst_dec");
        step(X,    1, 7, 7, "post_rst_ex");

        @(negedge clk);
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
